// File: rtl/fir_in_rate_gen_if.sv
// Stream/config bundle for fir_in_rate_gen: config strobe, input sample stream, tagged output stream.
interface fir_in_rate_gen_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_W   = 1,
  parameter int unsigned RATE_W = 4,
  parameter int unsigned TAIL_W = 8
);
  logic              cfg_valid;
  logic              cfg_mode;
  logic [RATE_W-1:0] cfg_rate;
  logic [TAIL_W-1:0] cfg_tail;
  logic              cfg_ready;

  logic              in_valid;
  logic [DATA_W-1:0] in_data_r;
  logic [DATA_W-1:0] in_data_i;
  logic              in_last;
  logic              in_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data_r;
  logic [DATA_W-1:0] out_data_i;
  logic [CH_W-1:0]   out_ch;
  logic              out_last;
  logic              out_ready;

  logic              busy;

  modport master (
    output cfg_valid, cfg_mode, cfg_rate, cfg_tail,
    output in_valid, in_data_r, in_data_i, in_last,
    output out_ready,
    input  cfg_ready, in_ready,
    input  out_valid, out_data_r, out_data_i, out_ch, out_last,
    input  busy
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_rate, cfg_tail,
    input  in_valid, in_data_r, in_data_i, in_last,
    input  out_ready,
    output cfg_ready, in_ready,
    output out_valid, out_data_r, out_data_i, out_ch, out_last,
    output busy
  );
endinterface

// File: rtl/fir_in_rate_gen.sv
// FIR input-rate stage: zero-stuff interpolation, round-robin channel tagging, per-channel zero tail.
// Optional FIR_IN_RATE_STATS_EN adds saturating input/output handshake counters.
module fir_in_rate_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned RATE_W = 4,
  parameter int unsigned TAIL_W = 8
) (
  input  logic clk,
  input  logic rst,
  fir_in_rate_gen_if.slave bus
`ifdef FIR_IN_RATE_STATS_EN
  ,
  output logic [31:0] stat_in_cnt,
  output logic [31:0] stat_out_cnt
`endif
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, STUFF, TAIL} state_t;

  state_t            state, state_nx;
  logic [CH_W-1:0]   ch_cnt, ch_nx;
  logic [RATE_W-1:0] rate_q, rate_nx;
  logic [RATE_W-1:0] zcnt, zcnt_nx;
  logic [TAIL_W-1:0] tail_q, tail_nx;
  logic [TAIL_W-1:0] trem, trem_nx;
  logic              last_pend, last_pend_nx;

  logic              ov, ov_nx;
  logic [DATA_W-1:0] od_r, od_r_nx;
  logic [DATA_W-1:0] od_i, od_i_nx;
  logic [CH_W-1:0]   och, och_nx;
  logic              olast, olast_nx;

  logic              load;
  logic              accept;
  logic              cfg_acc;
  logic [CH_W-1:0]   ch_inc;

  assign load    = !ov || bus.out_ready;
  assign accept  = bus.in_valid && (state == STREAM) && load;
  assign cfg_acc = bus.cfg_valid && (state == IDLE);
  assign ch_inc  = (ch_cnt == CH_LAST) ? '0 : ch_cnt + CH_W'(1);

  // Next-state and next-output-register logic
  always_comb begin
    state_nx     = state;
    ch_nx        = ch_cnt;
    rate_nx      = rate_q;
    zcnt_nx      = zcnt;
    tail_nx      = tail_q;
    trem_nx      = trem;
    last_pend_nx = last_pend;
    ov_nx        = ov;
    od_r_nx      = od_r;
    od_i_nx      = od_i;
    och_nx       = och;
    olast_nx     = olast;

    // A drained register empties unless a new sample loads below
    if (load) begin
      ov_nx    = 1'b0;
      olast_nx = 1'b0;
    end

    case (state)
      IDLE: begin
        if (bus.cfg_valid) begin
          rate_nx      = (!bus.cfg_mode || bus.cfg_rate == '0) ? RATE_W'(1) : bus.cfg_rate;
          tail_nx      = bus.cfg_tail;
          ch_nx        = '0;
          last_pend_nx = 1'b0;
          state_nx     = STREAM;
        end
      end

      STREAM: begin
        if (accept) begin
          ov_nx    = 1'b1;
          od_r_nx  = bus.in_data_r;
          od_i_nx  = bus.in_data_i;
          och_nx   = ch_cnt;
          olast_nx = bus.in_last && (rate_q == RATE_W'(1)) && (tail_q == '0);
          if (rate_q > RATE_W'(1)) begin
            zcnt_nx      = rate_q - RATE_W'(1);
            last_pend_nx = bus.in_last;
            state_nx     = STUFF;
          end else if (bus.in_last) begin
            ch_nx    = '0;
            trem_nx  = tail_q;
            state_nx = (tail_q == '0) ? IDLE : TAIL;
          end else begin
            ch_nx = ch_inc;
          end
        end
      end

      STUFF: begin
        if (load) begin
          ov_nx    = 1'b1;
          od_r_nx  = '0;
          od_i_nx  = '0;
          och_nx   = ch_cnt;
          olast_nx = (zcnt == RATE_W'(1)) && last_pend && (tail_q == '0);
          zcnt_nx  = zcnt - RATE_W'(1);
          if (zcnt == RATE_W'(1)) begin
            if (last_pend) begin
              ch_nx    = '0;
              trem_nx  = tail_q;
              state_nx = (tail_q == '0) ? IDLE : TAIL;
            end else begin
              ch_nx    = ch_inc;
              state_nx = STREAM;
            end
          end
        end
      end

      TAIL: begin
        // trem counts remaining rounds over all channels
        if (load) begin
          ov_nx   = 1'b1;
          od_r_nx = '0;
          od_i_nx = '0;
          och_nx  = ch_cnt;
          if (ch_cnt == CH_LAST) begin
            ch_nx   = '0;
            trem_nx = trem - TAIL_W'(1);
            if (trem == TAIL_W'(1)) begin
              olast_nx = 1'b1;
              state_nx = IDLE;
            end
          end else begin
            ch_nx = ch_inc;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch_cnt    <= '0;
      rate_q    <= RATE_W'(1);
      zcnt      <= '0;
      tail_q    <= '0;
      trem      <= '0;
      last_pend <= 1'b0;
      ov        <= 1'b0;
      od_r      <= '0;
      od_i      <= '0;
      och       <= '0;
      olast     <= 1'b0;
    end else begin
      state     <= state_nx;
      ch_cnt    <= ch_nx;
      rate_q    <= rate_nx;
      zcnt      <= zcnt_nx;
      tail_q    <= tail_nx;
      trem      <= trem_nx;
      last_pend <= last_pend_nx;
      ov        <= ov_nx;
      od_r      <= od_r_nx;
      od_i      <= od_i_nx;
      och       <= och_nx;
      olast     <= olast_nx;
    end
  end

  assign bus.cfg_ready  = (state == IDLE);
  assign bus.in_ready   = (state == STREAM) && load;
  assign bus.out_valid  = ov;
  assign bus.out_data_r = od_r;
  assign bus.out_data_i = od_i;
  assign bus.out_ch     = och;
  assign bus.out_last   = olast;
  assign bus.busy       = (state != IDLE);

`ifdef FIR_IN_RATE_STATS_EN
  // Saturating job statistics, cleared when a job is configured
  always_ff @(posedge clk) begin
    if (rst || cfg_acc) begin
      stat_in_cnt  <= '0;
      stat_out_cnt <= '0;
    end else begin
      if (accept && stat_in_cnt != '1)
        stat_in_cnt <= stat_in_cnt + 32'd1;
      if (ov && bus.out_ready && stat_out_cnt != '1)
        stat_out_cnt <= stat_out_cnt + 32'd1;
    end
  end
`else
  logic unused_cfg_acc;
  assign unused_cfg_acc = cfg_acc;
`endif

endmodule
